led_step_ctrl: RTL and testbench

LED_STEP_CTRL -- requirements
Module: led_step_ctrl

---
 rtl/led_pkg.sv | 14 +
 rtl/key_debounce.sv | 53 +++++
 rtl/led_step_ctrl.sv | 109 ++++++++++
 tb/tb_led_step_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the LED stepping controller.
package led_pkg;

    typedef enum logic [1:0] {
        RUN_R = 2'd0,
        RUN_L = 2'd1,
        PAUSE = 2'd2
    } mode_e;

    localparam int SPEED_W   = 2;
    localparam int KEY_SPEED = 0;
    localparam int KEY_MODE  = 1;

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, counting debouncer and a one-cycle
// press pulse that fires when the debounced level falls.
module key_debounce #(
    parameter int DEB_CYCLES = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic press_o
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The pulse is registered alongside the stable level so it lines up with the fall.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                press_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= key_n_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/led_step_ctrl.sv
// LED rotation controller: two debounced keys drive a speed index and a
// run/direction mode FSM; a restartable divider produces the step strobe.
module led_step_ctrl
    import led_pkg::*;
#(
    parameter int DEB_CYCLES = 20,
    parameter int BASE_DIV   = 50
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         key_n,
    output logic               step_tick,
    output logic               dir,
    output logic               run,
    output logic [SPEED_W-1:0] speed,
    output logic [1:0]         key_evt
);

    localparam int DIV_W = $clog2(BASE_DIV * 8);

    function automatic logic [DIV_W-1:0] last_cnt(input logic [SPEED_W-1:0] spd);
        return DIV_W'((BASE_DIV << (3 - int'(spd))) - 1);
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_key
        key_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .key_n_i(key_n[k]),
            .press_o(key_evt[k])
        );
    end

    mode_e              mode_q, mode_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic               run_q, run_d;
    logic               dir_q, dir_d;
    logic               tick_q, tick_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               restart_q;
    logic               clr;

    always_comb begin
        mode_d  = mode_q;
        speed_d = speed_q;
        dir_d   = dir_q;
        clr     = restart_q;
        div_d   = '0;
        tick_d  = 1'b0;

        if (key_evt[KEY_SPEED]) begin
            speed_d = speed_q + SPEED_W'(1);
            clr     = 1'b1;
        end

        if (key_evt[KEY_MODE]) begin
            case (mode_q)
                RUN_R:   mode_d = RUN_L;
                RUN_L:   mode_d = PAUSE;
                default: begin
                    mode_d = RUN_R;
                    clr    = 1'b1;
                end
            endcase
        end

        run_d = (mode_d != PAUSE);
        if (mode_d == RUN_R) begin
            dir_d = 1'b0;
        end else if (mode_d == RUN_L) begin
            dir_d = 1'b1;
        end

        // Without a clear the speed is unchanged, so speed_q selects the period.
        if (!clr && run_d) begin
            div_d  = (div_q == last_cnt(speed_q)) ? '0 : div_q + DIV_W'(1);
            tick_d = (div_d == last_cnt(speed_q));
        end
    end

    // restart_q makes the first post-reset cycle behave like a divider clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q    <= RUN_R;
            speed_q   <= '0;
            run_q     <= 1'b1;
            dir_q     <= 1'b0;
            tick_q    <= 1'b0;
            div_q     <= '0;
            restart_q <= 1'b1;
        end else begin
            mode_q    <= mode_d;
            speed_q   <= speed_d;
            run_q     <= run_d;
            dir_q     <= dir_d;
            tick_q    <= tick_d;
            div_q     <= div_d;
            restart_q <= 1'b0;
        end
    end

    assign step_tick = tick_q;
    assign dir       = dir_q;
    assign run       = run_q;
    assign speed     = speed_q;

endmodule

// File: tb/tb_led_step_ctrl.sv
// Bench for led_step_ctrl: directed key scenarios plus random key activity,
// every cycle compared against a behavioural model of the key/mode/tick rules.
module tb_led_step_ctrl;

    localparam int DEB  = 5;
    localparam int BDIV = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] key_n = 2'b11;
    logic       step_tick, dir, run;
    logic [1:0] speed;
    logic [1:0] key_evt;

    always #5 clk = ~clk;

    led_step_ctrl #(
        .DEB_CYCLES(DEB),
        .BASE_DIV  (BDIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_n    (key_n),
        .step_tick(step_tick),
        .dir      (dir),
        .run      (run),
        .speed    (speed),
        .key_evt  (key_evt)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state; mode 0 = RUN_R, 1 = RUN_L, 2 = PAUSE.
    logic [1:0]     m_s1 = 2'b11, m_s2 = 2'b11, m_stab = 2'b11, m_evt = 2'b00;
    logic [DEB-1:0] m_hist [2];
    int             m_mode = 0, m_speed = 0, m_anchor = 0;
    logic           m_dir = 1'b0, m_run = 1'b1, m_tick = 1'b0, m_pend = 1'b1;

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // One rising edge of the model: debounced level flips once the last DEB
    // synchronized samples all disagree with it; period = BDIV * 2^(3-speed).
    task automatic model_edge();
        logic [1:0] evt_prev;
        logic       restart;
        int         p;
        cyc++;
        if (!rst_n) begin
            m_s1 = 2'b11; m_s2 = 2'b11; m_stab = 2'b11; m_evt = 2'b00;
            m_hist[0] = '1; m_hist[1] = '1;
            m_mode = 0; m_speed = 0; m_dir = 1'b0; m_run = 1'b1;
            m_tick = 1'b0; m_pend = 1'b1;
        end else begin
            evt_prev = m_evt;
            for (int i = 0; i < 2; i++) begin
                m_hist[i] = {m_hist[i][DEB-2:0], m_s2[i]};
                m_evt[i]  = 1'b0;
                if (m_hist[i] == {DEB{~m_stab[i]}}) begin
                    m_stab[i] = ~m_stab[i];
                    m_evt[i]  = ~m_stab[i];
                end
            end
            m_s2 = m_s1;
            m_s1 = key_n;

            restart = m_pend;
            m_pend  = 1'b0;
            if (evt_prev[0]) begin
                m_speed = (m_speed + 1) % 4;
                restart = 1'b1;
            end
            if (evt_prev[1]) begin
                m_mode = (m_mode + 1) % 3;
                if (m_mode == 0) restart = 1'b1;
            end
            m_run = (m_mode != 2);
            if (m_mode == 0) m_dir = 1'b0;
            else if (m_mode == 1) m_dir = 1'b1;
            if (restart) m_anchor = cyc;
            p      = BDIV * (1 << (3 - m_speed));
            m_tick = m_run && (((cyc - m_anchor) % p) == p - 1);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_val("step_tick", step_tick, m_tick);
        check_val("run", run, m_run);
        check_val("dir", dir, m_dir);
        check_val("speed", speed, m_speed);
        check_val("key_evt", key_evt, m_evt);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic press(input logic [1:0] m, input int hold);
        key_n = ~m;
        idle(hold);
        key_n = 2'b11;
        idle(DEB + 6);
    endtask

    task automatic glitch(input int b, input int len);
        key_n[b] = 1'b0;
        idle(len);
        key_n = 2'b11;
        idle(DEB + 6);
    endtask

    task automatic reset_pulse(input int n);
        int lat;
        rst_n = 1'b0;
        idle(n);
        rst_n = 1'b1;
        lat = 0;
        while (lat < 100) begin
            step();
            lat++;
            if (step_tick) break;
        end
        check_val("rst_first_tick", lat, BDIV * 8);
    endtask

    initial begin
        int tk;
        int r;
        m_hist[0] = '1;
        m_hist[1] = '1;

        // Reset, then idle stepping at the slowest speed.
        reset_pulse(3);
        idle(70);

        glitch(0, 3);
        check_val("glitch_speed", speed, 0);

        press(2'b01, 20);
        press(2'b01, 20);
        press(2'b01, 20);
        check_val("speed_after3", speed, 3);
        idle(20);
        press(2'b01, 20);
        idle(40);

        press(2'b10, 20);
        idle(40);
        press(2'b10, 20);
        tk = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            tk += int'(step_tick);
        end
        check_val("pause_ticks", tk, 0);
        press(2'b10, 20);
        idle(50);

        press(2'b11, 20);
        idle(30);

        // Speed 2 in RUN_L, reset mid-period.
        press(2'b01, 20);
        idle(13);
        reset_pulse(2);
        idle(40);

        for (int it = 0; it < 50; it++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1:    idle(int'($urandom_range(1, 60)));
                2, 3:    press(2'b01, int'($urandom_range(DEB + 1, 25)));
                4, 5:    press(2'b10, int'($urandom_range(DEB + 1, 25)));
                6:       press(2'b11, int'($urandom_range(DEB + 1, 25)));
                7, 8:    glitch(int'($urandom_range(0, 1)), int'($urandom_range(1, DEB - 1)));
                default: reset_pulse(int'($urandom_range(1, 3)));
            endcase
        end
        idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
